// File: rtl/ascii_segment_decoder_pkg.sv
// ascii_segment_decoder_pkg: segment patterns, ASCII codes and FSM states shared by the decoder and the encoder.
package ascii_segment_decoder_pkg;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  typedef enum logic [1:0] {WAIT_HIGH, WAIT_LOW, WAIT_TERM, COMMIT} state_e;
endpackage

// File: rtl/ascii_segment_decoder_digit.sv
// ascii_digit_to_segment: maps an ASCII digit byte to its seven-segment pattern and flags whether it is a digit.
module ascii_digit_to_segment
  import ascii_segment_decoder_pkg::*;
(
  input  logic [7:0] ascii_i,
  output logic [6:0] seg_o,
  output logic       is_digit_o
);
  assign is_digit_o = ascii_i >= ASCII_ZERO && ascii_i <= ASCII_NINE;
  always_comb begin
    seg_o = SEG_BLANK;
    if (is_digit_o)
      case (ascii_i[3:0])
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        default: seg_o = SEG_9;
      endcase
  end
endmodule

// File: rtl/ascii_segment_decoder.sv
// ascii_segment_decoder: assembles a 1-2 digit ASCII floor number from a byte stream and commits it
// to a held 14-bit seven-segment display register on CR/LF.
module ascii_segment_decoder
  import ascii_segment_decoder_pkg::*;
#(
  parameter bit BLANK_LEADING_ZERO = 1'b0,
  parameter int TIMEOUT_CYCLES     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  asciIn,
  input  logic        asciValid,
  output logic        asciReady,
  output logic [13:0] ssOut,
  output logic        ssValid,
  output logic        errPulse
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [13:0] SS_RESET = {BLANK_LEADING_ZERO ? SEG_BLANK : SEG_0, SEG_0};

  state_e          state_q, state_d;
  logic [6:0]      hi_q, hi_d, lo_q, lo_d;
  logic [13:0]     ss_q, ss_d;
  logic            sv_q, sv_d, err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      seg;
  logic            is_digit, is_term, xfer, expired;

  ascii_digit_to_segment u_digit (
    .ascii_i    (asciIn),
    .seg_o      (seg),
    .is_digit_o (is_digit)
  );

  assign is_term   = asciIn == ASCII_CR || asciIn == ASCII_LF;
  assign asciReady = state_q != COMMIT;
  assign xfer      = asciValid && asciReady;
  assign expired   = TIMEOUT_CYCLES > 0 && (state_q == WAIT_LOW || state_q == WAIT_TERM)
                     && cnt_q == CW'(TIMEOUT_CYCLES);
  assign ssOut     = ss_q;
  assign ssValid   = sv_q;
  assign errPulse  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_HIGH;
      hi_q    <= '0;
      lo_q    <= '0;
      ss_q    <= SS_RESET;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ss_q    <= ss_d;
      sv_q    <= sv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HIGH: state_d = xfer && is_digit ? WAIT_LOW : WAIT_HIGH;
      WAIT_LOW:  state_d = xfer ? (is_digit ? WAIT_TERM : is_term ? COMMIT : WAIT_HIGH)
                                : expired ? WAIT_HIGH : WAIT_LOW;
      WAIT_TERM: state_d = xfer ? (is_term ? COMMIT : WAIT_HIGH) : expired ? WAIT_HIGH : WAIT_TERM;
      default:   state_d = WAIT_HIGH;
    endcase
  end

  // A single-digit entry is shifted into the low slot so COMMIT always shows {hi_q, lo_q}.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    ss_d  = ss_q;
    sv_d  = 1'b0;
    err_d = 1'b0;
    cnt_d = '0;
    case (state_q)
      WAIT_HIGH: begin
        hi_d  = xfer && is_digit ? seg : hi_q;
        err_d = xfer && !is_digit && !is_term;
      end
      WAIT_LOW: begin
        hi_d  = xfer && is_term ? SEG_0 : hi_q;
        lo_d  = xfer && is_term ? hi_q : xfer && is_digit ? seg : lo_q;
        err_d = xfer ? !is_digit && !is_term : expired;
        cnt_d = TIMEOUT_CYCLES == 0 || xfer || expired ? '0 : cnt_q + 1'b1;
      end
      WAIT_TERM: begin
        err_d = xfer ? !is_term : expired;
        cnt_d = TIMEOUT_CYCLES == 0 || xfer || expired ? '0 : cnt_q + 1'b1;
      end
      COMMIT: begin
        ss_d = {BLANK_LEADING_ZERO && hi_q == SEG_0 ? SEG_BLANK : hi_q, lo_q};
        sv_d = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ascii_segment_decoder.sv
// tb_ascii_segment_decoder: two decoder instances (plain / blanking+timeout 4) driven by a shared byte stream
// and checked every cycle against a digit-list model of the entry rules.
module tb_ascii_segment_decoder;
  logic        clk = 1'b0, rst_n = 1'b0, asciValid = 1'b0;
  logic [7:0]  asciIn = 8'h00;
  logic [1:0]  rdy, sv, er;
  logic [13:0] ss [2];
  int          total_cnt = 0, pass_cnt = 0;

  ascii_segment_decoder #(.BLANK_LEADING_ZERO(1'b0), .TIMEOUT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .asciIn(asciIn), .asciValid(asciValid), .asciReady(rdy[0]),
    .ssOut(ss[0]), .ssValid(sv[0]), .errPulse(er[0]));
  ascii_segment_decoder #(.BLANK_LEADING_ZERO(1'b1), .TIMEOUT_CYCLES(4)) u1 (
    .clk(clk), .rst_n(rst_n), .asciIn(asciIn), .asciValid(asciValid), .asciReady(rdy[1]),
    .ssOut(ss[1]), .ssValid(sv[1]), .errPulse(er[1]));

  always #5 clk = ~clk;

  int   tmo [2] = '{0, 4};
  bit   blz [2] = '{1'b0, 1'b1};
  int   n [2], idle [2], phi [2], plo [2];
  int   dg [2][2];
  bit   pend [2], e_sv [2], e_err [2];
  logic [13:0] e_ss [2];

  function automatic logic [6:0] pat(int d);
    case (d)
      0: return 7'b1111110; 1: return 7'b0110000; 2: return 7'b1101101; 3: return 7'b1111001;
      4: return 7'b0110011; 5: return 7'b1011011; 6: return 7'b1011111; 7: return 7'b1110000;
      8: return 7'b1111111; default: return 7'b1111011;
    endcase
  endfunction

  function automatic logic [13:0] disp(int i, int h, int l);
    return {(blz[i] && h == 0) ? 7'b0000000 : pat(h), pat(l)};
  endfunction

  task automatic chk(string nm, logic [13:0] act, logic [13:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset(int i);
    n[i] = 0; idle[i] = 0; pend[i] = 0; e_ss[i] = disp(i, 0, 0); e_sv[i] = 0; e_err[i] = 0;
  endtask

  // Predicts the outputs after the next rising edge from the inputs currently presented.
  task automatic model_step(int i);
    bit dig, term;
    e_sv[i] = 0;
    e_err[i] = 0;
    dig  = asciIn >= 8'h30 && asciIn <= 8'h39;
    term = asciIn == 8'h0D || asciIn == 8'h0A;
    if (pend[i]) begin
      pend[i] = 0; e_ss[i] = disp(i, phi[i], plo[i]); e_sv[i] = 1;
    end else if (asciValid) begin
      idle[i] = 0;
      if (dig && n[i] < 2) begin
        dg[i][n[i]] = int'(asciIn) - 48; n[i]++;
      end else if (term && n[i] > 0) begin
        pend[i] = 1; phi[i] = n[i] == 2 ? dg[i][0] : 0; plo[i] = dg[i][n[i] - 1]; n[i] = 0;
      end else if (!(term && n[i] == 0)) begin
        e_err[i] = 1; n[i] = 0;
      end
    end else if (n[i] > 0 && tmo[i] > 0) begin
      if (idle[i] == tmo[i]) begin
        e_err[i] = 1; n[i] = 0; idle[i] = 0;
      end else idle[i]++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      chk($sformatf("ssOut[%0d]", i), ss[i], e_ss[i]);
      chk($sformatf("ssValid[%0d]", i), 14'(sv[i]), 14'(e_sv[i]));
      chk($sformatf("errPulse[%0d]", i), 14'(er[i]), 14'(e_err[i]));
      chk($sformatf("asciReady[%0d]", i), 14'(rdy[i]), 14'(!pend[i]));
      model_step(i);
    end
  end

  task automatic send(logic [7:0] b);
    asciIn = b; asciValid = 1'b1;
    @(posedge clk); #1;
    asciValid = 1'b0;
  endtask

  task automatic idle_cyc(int k);
    asciValid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst ss0", ss[0], 14'b1111110_1111110);
    chk("rst ss1", ss[1], 14'b0000000_1111110);
    chk("rst rdy", 14'(rdy), 14'b11);
    chk("rst sv", 14'(sv), 14'b00);
    send(8'h34); send(8'h32); send(8'h0D); idle_cyc(1);
    chk("42 ss0", ss[0], 14'b0110011_1101101);
    chk("42 sv0", 14'(sv[0]), 14'd1);
    send(8'h37); send(8'h0A); idle_cyc(1);
    chk("7 ss1", ss[1], 14'b0000000_1110000);
    chk("7 ss0", ss[0], 14'b1111110_1110000);
    send(8'h31); send(8'h32); send(8'h33);
    chk("123 err", 14'(er), 14'b11);
    send(8'h0D); idle_cyc(2);
    chk("123 ss0", ss[0], 14'b1111110_1110000);
    send(8'h35); idle_cyc(5);
    chk("tmo err1", 14'(er[1]), 14'd1);
    send(8'h0D); idle_cyc(1);
    chk("tmo ss0", ss[0], 14'b1111110_1011011);
    chk("tmo ss1", ss[1], 14'b0000000_1110000);
    send(8'h35); idle_cyc(4); send(8'h0A);
    chk("edge err1", 14'(er[1]), 14'd0);
    idle_cyc(1);
    chk("edge ss1", ss[1], 14'b0000000_1011011);
    send(8'h39); send(8'h0D);
    rst_n = 1'b0; asciIn = 8'h38; asciValid = 1'b1;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 asciValid = 1'b0;
    chk("rstc ss0", ss[0], 14'b1111110_1111110);
    chk("rstc ss1", ss[1], 14'b0000000_1111110);
    chk("rstc sv", 14'(sv), 14'b00);
    send(8'h0D); idle_cyc(1);
    chk("8 ss0", ss[0], 14'b1111110_1111111);
    chk("8 ss1", ss[1], 14'b0000000_1111111);
    for (int k = 0; k < 500; k++) begin
      int r;
      if ($urandom_range(0, 9) < 3) idle_cyc($urandom_range(1, 7));
      else begin
        r = $urandom_range(0, 19);
        send(r < 12 ? 8'(8'h30 + $urandom_range(0, 9)) : r < 17 ? (r[0] ? 8'h0D : 8'h0A)
                    : 8'($urandom_range(0, 255)));
      end
    end
    idle_cyc(3);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ascii_segment_decoder.md
Name: ascii_segment_decoder

Overview:
- Turns a two-digit ASCII floor number from a byte stream (UART receive path / host link) back into the 14-bit seven-segment pattern driven to the elevator floor display.
- It is the inverse of the segment-to-ASCII encoder. It uses the same segment bit order and the same digit patterns.
- Bytes arrive over a valid/ready handshake. A line terminator commits the assembled number to a held display register.
- Malformed or stalled input is discarded and flagged.

Parameters:
- BLANK_LEADING_ZERO, 0: when 1, a high digit of 0 is driven as all-segments-off (7'b0000000).
- TIMEOUT_CYCLES, 0: idle cycles allowed inside a partial entry before it is aborted. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- asciIn  in  8  incoming ASCII byte
- asciValid  in  1  asciIn valid this cycle
- asciReady  out  1  decoder can accept a byte; a transfer happens when asciValid && asciReady
- ssOut  out  14  display pattern; [13:7] high digit, [6:0] low digit; bit order a..g, MSB = a
- ssValid  out  1  one-cycle pulse when ssOut has just been updated
- errPulse  out  1  one-cycle pulse when an entry is discarded

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n); release is synchronised externally.
- Digit patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Digit bytes are 0x30..0x39. Terminators are CR 0x0D and LF 0x0A. Every other byte is invalid.
- Reset values:
  - State = WAIT_HIGH; digit holding registers cleared.
  - ssOut = {SEG_0, SEG_0}, or {SEG_BLANK, SEG_0} when BLANK_LEADING_ZERO=1.
  - ssValid=0, errPulse=0, asciReady=1, timeout counter=0.
- FSM states: WAIT_HIGH, WAIT_LOW, WAIT_TERM, COMMIT.
- WAIT_HIGH (no digit held):
  - digit -> store as first digit, go to WAIT_LOW.
  - terminator -> ignored (empty line), no error.
  - invalid byte -> errPulse, stay in WAIT_HIGH.
- WAIT_LOW (one digit held):
  - digit -> store as second digit, go to WAIT_TERM.
  - terminator -> single-digit entry: high = 0, low = first digit; go to COMMIT.
  - invalid byte -> errPulse, discard, go to WAIT_HIGH.
- WAIT_TERM (two digits held):
  - terminator -> high = first digit, low = second digit; go to COMMIT.
  - digit (third digit) or invalid byte -> errPulse, discard, go to WAIT_HIGH.
- COMMIT:
  - asciReady=0 for exactly one cycle.
  - At the closing edge, ssOut is loaded, ssValid=1 for one cycle, state returns to WAIT_HIGH.
  - Latency: terminator accepted at edge N; ssOut/ssValid visible after edge N+1.
- asciReady is high in every state except COMMIT.
- ssOut holds its value between commits. Errors and timeouts never change ssOut.
- errPulse is registered: it is high the cycle after the offending transfer or the timeout expiry.
- BLANK_LEADING_ZERO applies to the high digit at commit time only. The low digit is never blanked, so 0 shows as blank + SEG_0.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs only in WAIT_LOW and WAIT_TERM. It clears on every accepted byte and on entering WAIT_HIGH.
  - When it reaches TIMEOUT_CYCLES: errPulse, discard, go to WAIT_HIGH.
  - A transfer in the same cycle as expiry wins: the byte is processed normally and the counter clears.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Reset mid-entry or during COMMIT: everything returns immediately to reset values. A pending commit is lost and no ssValid is produced.
- Back-to-back bytes: one byte per cycle in all non-COMMIT states. There are no wait states other than COMMIT.

Decomposition:
- Shared package holds:
  - SEG_0..SEG_9, SEG_BLANK
  - ASCII_ZERO (0x30), ASCII_NINE (0x39), ASCII_CR, ASCII_LF
  - the FSM state enum
- The encoder should migrate to the same segment constants.
- One natural sub-module, ascii_digit_to_segment: combinational; 8-bit ASCII in -> 7-bit pattern plus isDigit flag.
- The FSM, digit registers, timeout counter and output registers stay in ascii_segment_decoder.

Test Plan:
- Reset with BLANK_LEADING_ZERO=0 -> ssOut=14'b1111110_1111110, ssValid=0, asciReady=1.
- Bytes 0x34,0x32,0x0D back-to-back -> asciReady low one cycle; ssOut=1111110/1111110 replaced by 0110011_1101101; one ssValid pulse; errPulse never high.
- Bytes 0x37,0x0A with BLANK_LEADING_ZERO=1 -> ssOut=0000000_1110000, ssValid once.
- Bytes 0x31,0x32,0x33 -> errPulse after the 0x33 transfer; a following 0x0D is ignored; ssOut unchanged; no ssValid.
- TIMEOUT_CYCLES=4: byte 0x35, then asciValid=0 for 4 cycles -> errPulse, state WAIT_HIGH. Repeat with 0x0A delivered on the expiry cycle -> commit of 05, no errPulse.
- Bytes 0x39,0x0D with rst_n pulsed low during the COMMIT cycle -> ssOut back to reset value, no ssValid; decoder accepts a new entry immediately after release.
